// File: rtl/spi_piso_tx_pkg.sv
// Shared definitions for the single-clock SPI-style link (transmitter and sipo receiver).
package spi_piso_tx_pkg;

    localparam int SPI_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } spi_state_t;

endpackage

// File: rtl/spi_piso_tx.sv
// SPI-style serial transmitter: one-word buffer, LSB-first shifter, registered ss/mosi/done.
// Frame = 1 arming cycle (ss low), WIDTH data cycles, then GAP_CYCLES with ss high.
module spi_piso_tx
    import spi_piso_tx_pkg::*;
#(
    parameter int WIDTH      = SPI_WIDTH,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             start,
    output logic             ready,
    output logic             ss,
    output logic             mosi,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    spi_state_t       state_q, state_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic             pending_q, pending_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic             ss_q, ss_d;
    logic             mosi_q, mosi_d;
    logic             done_q, done_d;
    logic             load;

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        pending_d = pending_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        ss_d      = ss_q;
        mosi_d    = mosi_q;
        done_d    = 1'b0;
        load      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ss_d   = 1'b1;
                mosi_d = 1'b0;
                load   = pending_q;
            end
            ST_SETUP: begin
                mosi_d    = shreg_q[0];
                shreg_d   = shreg_q >> 1;
                bit_cnt_d = '0;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bit_cnt_q == CW'(WIDTH - 1)) begin
                    ss_d      = 1'b1;
                    mosi_d    = 1'b0;
                    done_d    = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end else begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    mosi_d    = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                end
            end
            ST_GAP: begin
                ss_d   = 1'b1;
                mosi_d = 1'b0;
                if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
                    if (pending_q) load = 1'b1;
                    else           state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Buffer hands off to the shifter on the edge that enters SETUP.
        if (load) begin
            state_d   = ST_SETUP;
            ss_d      = 1'b0;
            shreg_d   = buf_q;
            pending_d = 1'b0;
        end

        // Acceptance only happens with the buffer empty, so it never collides with a load.
        if (start && !pending_q) begin
            buf_d     = data_in;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            buf_q     <= '0;
            pending_q <= 1'b0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            ss_q      <= 1'b1;
            mosi_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            pending_q <= pending_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            ss_q      <= ss_d;
            mosi_q    <= mosi_d;
            done_q    <= done_d;
        end
    end

    assign ready = !pending_q;
    assign ss    = ss_q;
    assign mosi  = mosi_q;
    assign done  = done_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_piso_tx.sv
// Directed bench for spi_piso_tx: decodes captured ss/mosi frames like the sipo receiver would.
module tb_spi_piso_tx;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] data_in, data3;
    logic         start, start3;
    logic         ready, ss, mosi, busy, done;
    logic         ready3, ss3, mosi3, busy3, done3;

    always #5 clk = ~clk;

    spi_piso_tx #(.WIDTH(W), .GAP_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .start(start), .ready(ready),
        .ss(ss), .mosi(mosi), .busy(busy), .done(done)
    );

    spi_piso_tx #(.WIDTH(W), .GAP_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .data_in(data3), .start(start3), .ready(ready3),
        .ss(ss3), .mosi(mosi3), .busy(busy3), .done(done3)
    );

    int tests = 0;
    int fails = 0;

    // Capture buffer, one sample per falling edge of the selected instance.
    logic sel;
    logic cap_en;
    int   cap_n;
    logic c_ss[256], c_mosi[256], c_done[256], c_rdy[256];

    // Frame decode results.
    int           nfr, ndone, done_idx, mosi_bad;
    logic [W-1:0] fw[8];
    int           flen[8], fst[8], fend[8];

    task automatic tick();
        @(negedge clk);
        if (cap_en && cap_n < 256) begin
            c_ss[cap_n]   = sel ? ss3    : ss;
            c_mosi[cap_n] = sel ? mosi3  : mosi;
            c_done[cap_n] = sel ? done3  : done;
            c_rdy[cap_n]  = sel ? ready3 : ready;
            cap_n++;
        end
    endtask

    task automatic begin_cap();
        cap_n  = 0;
        cap_en = 1'b1;
        tick();
    endtask

    task automatic send(input logic [W-1:0] w);
        for (int i = 0; i < 200; i++) begin
            if (sel ? ready3 : ready) begin
                if (sel) begin data3 = w; start3 = 1'b1; end
                else     begin data_in = w; start = 1'b1; end
                tick();
                start  = 1'b0;
                start3 = 1'b0;
                return;
            end
            tick();
        end
        tests++; fails++;
        $display("FAIL send_timeout: ready never rose for word %h", w);
    endtask

    task automatic analyze();
        bit inf;
        int pos;
        nfr = 0; ndone = 0; done_idx = -1; mosi_bad = 0; inf = 0; pos = 0;
        for (int i = 0; i < cap_n; i++) begin
            if (c_done[i]) begin
                ndone++;
                if (done_idx < 0) done_idx = i;
            end
            if (c_ss[i]) begin
                if (c_mosi[i]) mosi_bad++;
                if (inf) begin
                    inf = 0; fend[nfr-1] = i; flen[nfr-1] = pos + 1;
                end
            end else if (!inf) begin
                if (nfr < 8) begin
                    inf = 1; fst[nfr] = i; fw[nfr] = '0; pos = 0; nfr++;
                end
            end else begin
                pos++;
                if (pos <= W) fw[nfr-1][pos-1] = c_mosi[i];
            end
        end
        if (inf) begin
            fend[nfr-1] = cap_n; flen[nfr-1] = pos + 1;
        end
        cap_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        tests++; if (ss !== 1'b1)    begin fails++; $display("FAIL reset_ss: got %b want 1", ss); end
        tests++; if (mosi !== 1'b0)  begin fails++; $display("FAIL reset_mosi: got %b want 0", mosi); end
        tests++; if (done !== 1'b0)  begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        tests++; if (busy !== 1'b0)  begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", ready); end
        tests++; if (ss3 !== 1'b1 || ready3 !== 1'b1)
            begin fails++; $display("FAIL reset_gap3: ss3=%b ready3=%b want 1 1", ss3, ready3); end
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [W-1:0] seq;
        int bad;
        seq = 16'b1010_0101_1100_0011;  // bit k is the k-th mosi value on the wire
        sel = 1'b0;
        begin_cap();
        send(16'hA5C3);
        repeat (40) tick();
        analyze();
        tests++; if (nfr !== 1)     begin fails++; $display("FAIL single_nframes: got %0d want 1", nfr); end
        tests++; if (flen[0] !== 17) begin fails++; $display("FAIL single_ss_low_len: got %0d want 17", flen[0]); end
        tests++; if (fst[0] !== 2)   begin fails++; $display("FAIL single_ss_fall: got idx %0d want 2", fst[0]); end
        bad = 0;
        for (int k = 0; k < W; k++) if (c_mosi[3+k] !== seq[k]) bad++;
        tests++; if (bad !== 0)      begin fails++; $display("FAIL single_mosi_seq: %0d bits wrong, want 0", bad); end
        tests++; if (fw[0] !== 16'hA5C3) begin fails++; $display("FAIL single_word: got %h want a5c3", fw[0]); end
        tests++; if (ndone !== 1)    begin fails++; $display("FAIL single_done_cnt: got %0d want 1", ndone); end
        tests++; if (done_idx !== 19) begin fails++; $display("FAIL single_done_time: got idx %0d want 19", done_idx); end
        tests++; if (fend[0] !== 19) begin fails++; $display("FAIL single_ss_rise: got idx %0d want 19", fend[0]); end
        tests++; if (mosi_bad !== 0) begin fails++; $display("FAIL single_mosi_idle: %0d cycles mosi=1 with ss=1", mosi_bad); end
        tests++; if (busy !== 1'b0)  begin fails++; $display("FAIL single_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        begin_cap();
        send(16'h0001);
        send(16'h8000);
        repeat (50) tick();
        analyze();
        tests++; if (c_rdy[1] !== 1'b0) begin fails++; $display("FAIL b2b_ready_low: got %b want 0", c_rdy[1]); end
        tests++; if (c_rdy[2] !== 1'b1) begin fails++; $display("FAIL b2b_ready_rise: got %b want 1", c_rdy[2]); end
        tests++; if (nfr !== 2)         begin fails++; $display("FAIL b2b_nframes: got %0d want 2", nfr); end
        tests++; if (fw[0] !== 16'h0001 || fw[1] !== 16'h8000)
            begin fails++; $display("FAIL b2b_words: got %h %h want 0001 8000", fw[0], fw[1]); end
        tests++; if (fst[1] - fend[0] !== 1)
            begin fails++; $display("FAIL b2b_gap: got %0d want 1", fst[1] - fend[0]); end
        tests++; if (ndone !== 2)       begin fails++; $display("FAIL b2b_done_cnt: got %0d want 2", ndone); end
    endtask

    task automatic test_overrun();
        sel = 1'b0;
        begin_cap();
        start = 1'b1; data_in = 16'h1111; tick();
        data_in = 16'h2222; tick();
        data_in = 16'h3333; tick();
        start = 1'b0;
        repeat (50) tick();
        analyze();
        tests++; if (nfr !== 2) begin fails++; $display("FAIL overrun_nframes: got %0d want 2", nfr); end
        tests++; if (fw[0] !== 16'h1111 || fw[1] !== 16'h3333)
            begin fails++; $display("FAIL overrun_words: got %h %h want 1111 3333", fw[0], fw[1]); end
    endtask

    task automatic test_reset_mid();
        sel = 1'b0;
        begin_cap();
        send(16'hFFFF);
        repeat (6) tick();  // bit 4 is now on mosi
        tests++; if (ss !== 1'b0 || mosi !== 1'b1)
            begin fails++; $display("FAIL rmid_pre: ss=%b mosi=%b want 0 1", ss, mosi); end
        rst = 1'b1;
        #1;
        tests++; if (ss !== 1'b1 || mosi !== 1'b0)
            begin fails++; $display("FAIL rmid_outputs: ss=%b mosi=%b want 1 0", ss, mosi); end
        tests++; if (busy !== 1'b0 || ready !== 1'b1)
            begin fails++; $display("FAIL rmid_busy_ready: busy=%b ready=%b want 0 1", busy, ready); end
        repeat (2) tick();
        rst = 1'b0;
        repeat (25) tick();
        analyze();
        tests++; if (ndone !== 0) begin fails++; $display("FAIL rmid_no_done: got %0d want 0", ndone); end
        begin_cap();
        send(16'h00F0);
        repeat (25) tick();
        analyze();
        tests++; if (nfr !== 1 || fw[0] !== 16'h00F0 || flen[0] !== 17)
            begin fails++; $display("FAIL rmid_recover: n=%0d word=%h len=%0d want 1 00f0 17", nfr, fw[0], flen[0]); end
        tests++; if (ndone !== 1) begin fails++; $display("FAIL rmid_recover_done: got %0d want 1", ndone); end
    endtask

    task automatic test_gap3();
        sel = 1'b1;
        begin_cap();
        send(16'h1234);
        send(16'h5678);
        repeat (50) tick();
        analyze();
        tests++; if (nfr !== 2) begin fails++; $display("FAIL gap3_nframes: got %0d want 2", nfr); end
        tests++; if (fw[0] !== 16'h1234 || fw[1] !== 16'h5678)
            begin fails++; $display("FAIL gap3_words: got %h %h want 1234 5678", fw[0], fw[1]); end
        tests++; if (fst[1] - fend[0] !== 3)
            begin fails++; $display("FAIL gap3_gap: got %0d want 3", fst[1] - fend[0]); end
        sel = 1'b0;
    endtask

    task automatic test_ones_zeros();
        sel = 1'b0;
        begin_cap();
        send(16'hFFFF);
        repeat (25) tick();
        analyze();
        tests++; if (fw[0] !== 16'hFFFF || flen[0] !== 17)
            begin fails++; $display("FAIL ones_word: got %h len %0d want ffff 17", fw[0], flen[0]); end
        tests++; if (c_ss[fend[0]] !== 1'b1 || c_mosi[fend[0]] !== 1'b0)
            begin fails++; $display("FAIL ones_tail: ss=%b mosi=%b want 1 0", c_ss[fend[0]], c_mosi[fend[0]]); end
        tests++; if (mosi_bad !== 0) begin fails++; $display("FAIL ones_mosi_idle: got %0d want 0", mosi_bad); end
        begin_cap();
        send(16'h0000);
        repeat (25) tick();
        analyze();
        tests++; if (nfr !== 1 || fw[0] !== 16'h0000 || flen[0] !== 17)
            begin fails++; $display("FAIL zeros_word: n=%0d word=%h len=%0d want 1 0000 17", nfr, fw[0], flen[0]); end
        tests++; if (ndone !== 1) begin fails++; $display("FAIL zeros_done: got %0d want 1", ndone); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start3 = 1'b0; data_in = '0; data3 = '0;
        sel = 1'b0; cap_en = 1'b0; cap_n = 0;
        tick();
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        test_gap3();
        test_ones_zeros();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
